fft_frame_src: RTL and testbench
================================

Name: fft_frame_src

Overview:
- Input-side framer for the radix-2 DIT FFT core.
- Collects a stream of unsigned offset-binary ADC samples into SIZE-entry complex frames.
- Presents a stable parallel frame on out[SIZE][2] to the FFT's in port.
- Responds to the FFT's req strobe so that each FFT load pass sees exactly one frame, unchanged for the whole load.
- Double-buffered: one fill bank, one presented bank.

Parameters:
- SIZE, 64, FFT points; power of two, 2..1024; equals FFT SIZE.
- RN, 16, result width; equals FFT RN.
- IN, 12, ADC sample width.
- SHIFT, 3, left shift applied to converted samples; IN+SHIFT <= RN.

Ports:
- clk  in  1  clock.
- n_reset  in  1  reset; asynchronous, active-low.
- in_valid  in  1  sample strobe, one sample per high cycle.
- in_data  in  IN  unsigned offset-binary ADC sample.
- req  in  1  FFT load request, high during each load cycle.
- out  out  [SIZE][2] x RN  presented frame; [k][0] real, [k][1] imag.
- full  out  1  fill bank holds a complete frame awaiting swap.
- overrun  out  1  sticky: a sample was dropped since the last swap.
- stale  out  1  current load started without a new frame (old frame re-presented).

Behaviour:
- Reset: both banks all-zero; wr_idx=0; fill bank=1, presented bank=0; lock counter=0; req_d=0; full=0, overrun=0, stale=0.
- Conversion per sample:
  - re = sign-extend(in_data with MSB inverted) << SHIFT, truncated to RN.
  - im = 0.
  - Example: 0x800 -> 0; 0xFFF -> 0x3FF8; 0x000 -> 0xC000 (IN=12, SHIFT=3, RN=16).
- Fill state machine (FILL, FULL):
  - FILL: on in_valid, write converted sample to fill[wr_idx] and increment wr_idx. When the SIZE-th sample is written, wr_idx wraps to 0 and the state moves to FULL; full is high from the next cycle.
  - FULL: in_valid samples are dropped; overrun goes high the next cycle and stays high until a swap.
- Swap condition: swap_now = req & ~req_d & (lock==0).
  - req_d is req registered.
- Swap when swap_now & FULL:
  - Bank pointers toggle at the clock edge.
  - out is driven combinationally from the incoming bank in the same cycle, so the FFT's first load cycle sees the new frame. This req->out mux path is intentional.
  - State returns to FILL; full and overrun clear; stale clears.
- Swap_now with state FILL:
  - No swap; the old frame stays presented; stale sets.
  - Fill continues unaffected.
- Lock counter:
  - Loads SIZE-1 on swap_now (whether or not banks swap).
  - Decrements on every cycle with req high while nonzero; cycles with req low do not count.
  - This covers the two SIZE/2 load passes and the inter-pass gap where req drops.
  - req rising edges while lock!=0 are ignored.
- out changes only on a swap. Between swaps it equals the presented bank exactly.
- Simultaneous events:
  - in_valid in a swap cycle (state FULL): the sample is written to index 0 of the newly freed bank; wr_idx becomes 1.
  - SIZE-th sample written in the same cycle as swap_now: treated as FILL, so no swap and stale sets. The frame becomes FULL for the next load.
  - overrun set and clear in the same cycle: clear wins.
- Reset mid-load or mid-fill: all state returns to reset values immediately; the partial frame is discarded.

Decomposition:
- Package fft_pkg:
  - cplx_t typedef, parameterised by RN via the module.
  - adc_to_fft() conversion function (MSB invert, sign-extend, shift).
  - Shared constants: default SIZE, RN.
- One sub-module, fft_frame_bank: a SIZE-entry complex register bank with write port (we, addr, d), async clear, and a full parallel read. Instantiated twice.
- Top contains the FSM, lock counter and out mux.

Test Plan (SIZE=8, RN=16, IN=12, SHIFT=3):
- Reset, then 8 samples 0x800..0x807 on consecutive cycles. Expect full=1 the cycle after the 8th; out all zero; overrun=0.
- With full=1, raise req for 4 cycles, drop 1 cycle, raise 4 more. Expect out[k][0]=k<<3 (0x0000..0x0038) and out[k][1]=0 from the first req cycle. Expect out unchanged through all 8 req cycles; the second rising edge is ignored. Expect full=0, stale=0.
- Load again with no new frame. Expect out unchanged and stale=1 from the cycle after the req rise.
- Fill 8 samples, then 3 more before req. Expect overrun=1 after the 9th sample. On swap: the presented frame is the first 8 samples; overrun clears.
- Fill with 0xFFF and 0x000 alternating. Expect out[even][0]=0x3FF8 and out[odd][0]=0xC000 after the swap.
- Pulse n_reset low mid-fill (after 5 samples) and mid-lock. Expect out all zero immediately and full=0. The next 8 samples plus req produce a normal swap.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, defaults and the ADC-to-FFT sample conversion for the FFT input path.
package fft_pkg;

    localparam int unsigned FFT_SIZE_DEF = 64;
    localparam int unsigned FFT_RN_DEF   = 16;

    // Complex word at the default result width: [1] imag, [0] real.
    typedef logic [1:0][FFT_RN_DEF-1:0] cplx_t;

    // Offset-binary to two's complement (MSB invert + sign-extend), then scale up.
    function automatic logic [31:0] adc_to_fft(input logic [31:0] data,
                                               input int unsigned in_w,
                                               input int unsigned shift);
        logic [31:0] v;
        v = data;
        v[in_w-1] = ~v[in_w-1];
        for (int unsigned i = 0; i < 32; i++) begin
            if (i >= in_w) v[i] = v[in_w-1];
        end
        return v << shift;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// SIZE-entry complex register bank: single write port, async clear, full parallel read.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned SIZE = FFT_SIZE_DEF,
    parameter int unsigned RN   = FFT_RN_DEF
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    we,
    input  logic [$clog2(SIZE)-1:0] addr,
    input  logic [RN-1:0]           d_re,
    input  logic [RN-1:0]           d_im,
    output logic [RN-1:0]           q [SIZE][2]
);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned k = 0; k < SIZE; k++) begin
                q[k][0] <= '0;
                q[k][1] <= '0;
            end
        end else if (we) begin
            q[addr][0] <= d_re;
            q[addr][1] <= d_im;
        end
    end

endmodule

// File: rtl/fft_frame_src.sv
// Double-buffered ADC framer: fills one bank while the other is presented to the FFT load port.
module fft_frame_src
    import fft_pkg::*;
#(
    parameter int unsigned SIZE  = FFT_SIZE_DEF,
    parameter int unsigned RN    = FFT_RN_DEF,
    parameter int unsigned IN    = 12,
    parameter int unsigned SHIFT = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          in_valid,
    input  logic [IN-1:0] in_data,
    input  logic          req,
    output logic [RN-1:0] out [SIZE][2],
    output logic          full,
    output logic          overrun,
    output logic          stale
);

    localparam int unsigned AW = $clog2(SIZE);
    localparam logic ST_FILL = 1'b0;
    localparam logic ST_FULL = 1'b1;

    logic          state;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] lock;
    logic          fill_sel;
    logic          req_d;

    logic          swap_now;
    logic          do_swap;
    logic          wr_bank;
    logic          we;
    logic          pres;
    logic [31:0]   conv_full;
    logic [RN-1:0] conv_re;
    logic [RN-1:0] q0 [SIZE][2];
    logic [RN-1:0] q1 [SIZE][2];

    assign conv_full = adc_to_fft(32'(in_data), IN, SHIFT);
    assign conv_re   = conv_full[RN-1:0];
    assign full      = (state == ST_FULL);

    // A sample arriving in the swap cycle lands in the bank being released, not the one going out.
    always_comb begin
        swap_now = req & ~req_d & (lock == '0);
        do_swap  = swap_now & (state == ST_FULL);
        wr_bank  = do_swap ? ~fill_sel : fill_sel;
        we       = in_valid & ((state == ST_FILL) | do_swap);
        pres     = do_swap ? fill_sel : ~fill_sel;
    end

    always_comb begin
        for (int unsigned k = 0; k < SIZE; k++) begin
            out[k][0] = pres ? q1[k][0] : q0[k][0];
            out[k][1] = pres ? q1[k][1] : q0[k][1];
        end
    end

    fft_frame_bank #(.SIZE(SIZE), .RN(RN)) u_bank0 (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (we & ~wr_bank),
        .addr    (wr_idx),
        .d_re    (conv_re),
        .d_im    ('0),
        .q       (q0)
    );

    fft_frame_bank #(.SIZE(SIZE), .RN(RN)) u_bank1 (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (we & wr_bank),
        .addr    (wr_idx),
        .d_re    (conv_re),
        .d_im    ('0),
        .q       (q1)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= ST_FILL;
            wr_idx   <= '0;
            lock     <= '0;
            fill_sel <= 1'b1;
            req_d    <= 1'b0;
            overrun  <= 1'b0;
            stale    <= 1'b0;
        end else begin
            req_d <= req;

            // Only req-high cycles count, so the gap between load passes keeps the frame locked.
            if (swap_now)
                lock <= AW'(SIZE - 1);
            else if (req && lock != '0)
                lock <= lock - AW'(1);

            if (do_swap)
                fill_sel <= ~fill_sel;

            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        wr_idx <= wr_idx + AW'(1);
                        if (wr_idx == AW'(SIZE - 1))
                            state <= ST_FULL;
                    end
                end
                default: begin
                    if (do_swap) begin
                        state  <= ST_FILL;
                        wr_idx <= in_valid ? AW'(1) : '0;
                    end
                end
            endcase

            if (do_swap)
                overrun <= 1'b0;
            else if (in_valid && state == ST_FULL)
                overrun <= 1'b1;

            if (do_swap)
                stale <= 1'b0;
            else if (swap_now)
                stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_src.sv
// Scoreboard bench for fft_frame_src: completed frames are queued as they are filled and popped at each swap.
module tb_fft_frame_src;

    localparam int SIZE = 8;
    localparam int RN   = 16;
    localparam int IN   = 12;
    localparam int FW   = SIZE * 2 * RN;

    logic          clk      = 1'b0;
    logic          n_reset  = 1'b0;
    logic          in_valid = 1'b0;
    logic [IN-1:0] in_data  = '0;
    logic          req      = 1'b0;
    logic [RN-1:0] out [SIZE][2];
    logic          full;
    logic          overrun;
    logic          stale;
    logic [FW-1:0] out_flat;

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] acc;
    logic [FW-1:0] cur_exp;
    int            m_cnt;
    bit            m_overrun;
    bit            m_stale;

    fft_frame_src #(.SIZE(SIZE), .RN(RN), .IN(IN), .SHIFT(3)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .req      (req),
        .out      (out),
        .full     (full),
        .overrun  (overrun),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    always_comb begin
        out_flat = '0;
        for (int k = 0; k < SIZE; k++) begin
            out_flat[(k*2)*RN +: RN]   = out[k][0];
            out_flat[(k*2+1)*RN +: RN] = out[k][1];
        end
    end

    function automatic logic [RN-1:0] conv(input logic [IN-1:0] s);
        int v;
        v = int'(s) - 2048;
        return RN'(v * 8);
    endfunction

    task automatic m_reset();
        exp_q.delete();
        acc       = '0;
        cur_exp   = '0;
        m_cnt     = 0;
        m_overrun = 0;
        m_stale   = 0;
    endtask

    task automatic m_accept(input logic [IN-1:0] s);
        if (m_cnt < SIZE) begin
            acc[(m_cnt*2)*RN +: RN]   = conv(s);
            acc[(m_cnt*2+1)*RN +: RN] = '0;
            m_cnt++;
            if (m_cnt == SIZE) exp_q.push_back(acc);
        end else begin
            m_overrun = 1;
        end
    endtask

    task automatic send(input logic [IN-1:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = s;
        m_accept(s);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        req      = 1'b0;
    endtask

    // Two 4-cycle req passes separated by a one-cycle gap; optional sample in the first req cycle.
    task automatic load(input bit with_sample, input logic [IN-1:0] s);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req      = (c != 4);
            in_valid = 1'b0;
            if (c == 0) begin
                if (exp_q.size() > 0) begin
                    cur_exp   = exp_q.pop_front();
                    m_cnt     = 0;
                    m_overrun = 0;
                    m_stale   = 0;
                end else begin
                    m_stale = 1;
                end
                if (with_sample) begin
                    in_valid = 1'b1;
                    in_data  = s;
                    m_accept(s);
                end
            end
            #1;
            checks++;
            if (out_flat !== cur_exp) begin
                errors++;
                $display("FAIL load_out c=%0d got=%h exp=%h", c, out_flat, cur_exp);
            end
            if (c == 1) begin
                checks++;
                if (stale !== m_stale) begin
                    errors++;
                    $display("FAIL load_stale got=%b exp=%b", stale, m_stale);
                end
            end
        end
        @(negedge clk);
        req      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (full !== (m_cnt == SIZE) || overrun !== m_overrun || stale !== m_stale) begin
            errors++;
            $display("FAIL load_flags got full=%b ovr=%b stale=%b exp full=%b ovr=%b stale=%b",
                     full, overrun, stale, (m_cnt == SIZE), m_overrun, m_stale);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (out_flat !== '0) begin
            errors++;
            $display("FAIL reset_out got=%h exp=0", out_flat);
        end
        checks++;
        if (full !== 1'b0 || overrun !== 1'b0 || stale !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got full=%b ovr=%b stale=%b exp 000", full, overrun, stale);
        end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < SIZE; i++) send(IN'(12'h800 + i));
        idle();
        #1;
        checks++;
        if (full !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags got full=%b ovr=%b exp full=1 ovr=0", full, overrun);
        end
        checks++;
        if (out_flat !== '0) begin
            errors++;
            $display("FAIL fill_out got=%h exp=0", out_flat);
        end
    endtask

    task automatic test_load();
        load(1'b0, '0);
        checks++;
        if (out[7][0] !== 16'h0038 || out[1][0] !== 16'h0008 || out[3][1] !== 16'h0000) begin
            errors++;
            $display("FAIL load_values got r7=%h r1=%h i3=%h exp 0038 0008 0000",
                     out[7][0], out[1][0], out[3][1]);
        end
    endtask

    task automatic test_stale();
        load(1'b0, '0);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < SIZE; i++) send(IN'(12'h100 + i * 37));
        idle();
        #1;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre got=%b exp=0", overrun);
        end
        for (int i = 0; i < 3; i++) send(IN'(12'hABC + i));
        idle();
        #1;
        checks++;
        if (overrun !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got ovr=%b full=%b exp ovr=1 full=1", overrun, full);
        end
        load(1'b0, '0);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < SIZE; i++) send((i % 2 == 0) ? 12'hFFF : 12'h000);
        idle();
        load(1'b0, '0);
        checks++;
        if (out[0][0] !== 16'h3FF8 || out[1][0] !== 16'hC000 || out[6][0] !== 16'h3FF8) begin
            errors++;
            $display("FAIL alt_values got r0=%h r1=%h r6=%h exp 3ff8 c000 3ff8",
                     out[0][0], out[1][0], out[6][0]);
        end
    endtask

    task automatic test_swap_with_sample();
        for (int i = 0; i < SIZE; i++) send(IN'($urandom_range(0, 4095)));
        idle();
        load(1'b1, IN'($urandom_range(0, 4095)));
        for (int i = 1; i < SIZE; i++) send(IN'($urandom_range(0, 4095)));
        idle();
        #1;
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL swap_sample_full got=%b exp=1", full);
        end
        load(1'b0, '0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send(IN'(12'h321 + i));
        @(negedge clk);
        in_valid = 1'b0;
        n_reset  = 1'b0;
        m_reset();
        #1;
        checks++;
        if (out_flat !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill got out=%h full=%b exp 0 0", out_flat, full);
        end
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < SIZE; i++) send(IN'(12'h900 - i * 5));
        idle();
        @(negedge clk);
        req       = 1'b1;
        cur_exp   = exp_q.pop_front();
        m_cnt     = 0;
        #1;
        checks++;
        if (out_flat !== cur_exp) begin
            errors++;
            $display("FAIL lock_swap got=%h exp=%h", out_flat, cur_exp);
        end
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b0;
        req     = 1'b0;
        m_reset();
        #1;
        checks++;
        if (out_flat !== '0 || full !== 1'b0 || stale !== 1'b0) begin
            errors++;
            $display("FAIL reset_lock got out=%h full=%b stale=%b exp 0 0 0", out_flat, full, stale);
        end
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < SIZE; i++) send(IN'($urandom_range(0, 4095)));
        idle();
        load(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_load();
        test_stale();
        test_overrun();
        test_alternate();
        test_swap_with_sample();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
